tff_bank_debounced: RTL
=======================

// Module: tff_bank_debounced
// PURPOSE
//  N-channel toggle/counter register bank driven by raw push-buttons. Replaces the fixed 3-bit TFF block.
//  Each button is synchronised, debounced and edge-detected on-chip. Presses then toggle LEDs or step an
//  N-bit up/down counter, selected by a run-time mode. Sits between the board buttons and the LED outputs.
// PARAMETERS
//  N_CH         3  number of channels / LED width (1..16)
//  SYNC_STAGES  2  synchroniser flops per button (>=2)
//  DB_CYCLES    4  consecutive stable samples needed to accept a level change (>=1)
// PORTS
//  sysclk   in   1            system clock, all flops on rising edge
//  reset_n  in   1            asynchronous, active-low reset
//  btn      in   N_CH         raw button levels, asynchronous to sysclk
//  mode     in   2            00 toggle, 01 count up, 10 count down, 11 hold
//  clr      in   1            synchronous clear of led
//  led      out  N_CH         registered bank state
//  press    out  N_CH         1-cycle pulse per accepted rising edge of each button
//  wrap     out  1            1-cycle pulse when the counter wraps
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - Sync chains, debounce counters, stable levels, led, press and wrap all go to 0.
//   - A button held across reset release is seen as a rising edge after the full latency.
//  Debounce, per channel:
//   - s = output of the sync chain. cnt increments while s != stable; cnt clears to 0 when s == stable.
//   - When cnt == DB_CYCLES-1 and s != stable, stable <= s and cnt <= 0.
//   - A mismatch lasting fewer than DB_CYCLES samples is ignored.
//  Latency:
//   - Counting edge 1 as the first sysclk edge after btn changes, stable, press and led update together at
//     edge SYNC_STAGES+DB_CYCLES. With defaults this is edge 6.
//   - press[i] is high for exactly one cycle on a 0->1 stable transition. Release produces no pulse.
//  led update, registered, same edge as press. Priority, highest first:
//   1. clr=1: led <= 0 and wrap <= 0; press pulses still emitted.
//   2. mode 00: led[i] <= led[i] ^ press[i] for all i. Simultaneous presses all toggle.
//   3. mode 01: on press[0], led <= led+1 mod 2^N_CH. press[1..] ignored for led.
//   4. mode 10: on press[0], led <= led-1 mod 2^N_CH.
//   5. mode 11: led holds.
//  wrap:
//   - Pulses on the same edge as led for 01 with all-ones->0, and for 10 with 0->all-ones.
//   - wrap is 0 in modes 00/11 and whenever clr=1.
//  mode / reset changes:
//   - A mode change mid-run keeps the led value; only the next update uses the new mode.
//   - mode is sampled on the edge that applies the press.
//   - Reset assertion mid-debounce discards the pending count. No partial pulses.
// STRUCTURE
//  - Shared package tff_bank_pkg: MODE_TOGGLE=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_HOLD=2'b11.
//  - Sub-module btn_debounce (one channel: sync chain, counter, stable level, rise pulse), generated N_CH
//    times. Parameters SYNC_STAGES and DB_CYCLES pass through.
//  - Top level holds the led/wrap update logic only.
// TESTING
//  Bench reads "btn mode" vectors from a file and writes "led press wrap" every cycle, like the existing
//  file-IO bench.
//  1. Reset + clean press: btn=001 held, mode=00, defaults -> press=001 and led=001 at edge 6 only.
//     Release then repress -> led=000.
//  2. Glitch reject: btn[1] high for 3 cycles then low -> press=000, led unchanged.
//     Held 4 cycles -> accepted at edge 6.
//  3. Count up wrap: mode=01, led=110, two btn[0] presses -> led 111, then 000 with wrap=1 for one cycle.
//     Presses on btn[2] leave led unchanged.
//  4. Count down wrap: mode=10, led=000, one btn[0] press -> led=111, wrap=1.
//  5. Simultaneous + clr: mode=00, btn=111 pressed together -> led=111. Next, clr=1 on the edge a new btn[0]
//     press lands -> led=000, press=001.
//  6. Async reset mid-debounce: reset_n low at cycle 3 of a press -> all outputs 0 immediately.
//     After release with btn still held -> press after full latency, led=001.

Source files
------------

// File: rtl/tff_bank_pkg.sv
// Shared definitions for the debounced toggle/counter bank.
// Contents: mode encoding, mode port width, and a width helper for the
// debounce counter.
package tff_bank_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel. The raw level is synchronised, then debounced.
// A rising edge of the debounced level produces a one-cycle pulse.
// Ports:
//   sysclk  - system clock
//   reset_n - async active-low reset
//   btn     - raw button level, asynchronous to sysclk
//   press   - registered 1-cycle pulse on an accepted 0->1 transition
//   rise_c  - combinational view of the same event, valid in the cycle
//             before press (lets the parent update on the same edge)
module btn_debounce
  import tff_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic btn,
  output logic press,
  output logic rise_c
);

  localparam int unsigned      CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   stable;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // The last mismatching sample of a long-enough run flips stable upward.
  assign rise_c = s & ~stable & (cnt == CNT_LAST);

  // Sync chain, mismatch run counter and accepted level.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      press <= rise_c;
      if (s != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= s;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/tff_bank_debounced.sv
// N-channel toggle / up-down counter bank driven by raw push-buttons.
// Every button is debounced per channel. The bank state changes on the
// same edge that emits the press pulse.
// Ports:
//   sysclk  - system clock, all flops on rising edge
//   reset_n - async active-low reset
//   btn     - raw button levels [N_CH-1:0]
//   mode    - 00 toggle, 01 count up, 10 count down, 11 hold
//   clr     - synchronous clear of led (wins over mode)
//   led     - registered bank state
//   press   - 1-cycle pulse per accepted rising edge of each button
//   wrap    - 1-cycle pulse when the counter wraps in either direction
module tff_bank_debounced
  import tff_bank_pkg::*;
#(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   btn,
  input  logic [MODE_W-1:0] mode,
  input  logic              clr,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   press,
  output logic              wrap
);

  logic [N_CH-1:0] rise_c;
  logic [N_CH-1:0] led_nxt;
  logic            wrap_nxt;

  // One debouncer per button.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_db (
      .sysclk (sysclk),
      .reset_n(reset_n),
      .btn    (btn[i]),
      .press  (press[i]),
      .rise_c (rise_c[i])
    );
  end

  // Next bank state. Only button 0 drives the counter modes.
  always_comb begin
    led_nxt  = led;
    wrap_nxt = 1'b0;
    if (clr) begin
      led_nxt = '0;
    end else begin
      case (mode_e'(mode))
        MODE_TOGGLE: led_nxt = led ^ rise_c;
        MODE_UP: begin
          if (rise_c[0]) begin
            led_nxt  = led + N_CH'(1);
            wrap_nxt = &led;
          end
        end
        MODE_DOWN: begin
          if (rise_c[0]) begin
            led_nxt  = led - N_CH'(1);
            wrap_nxt = ~|led;
          end
        end
        default: ;  // hold
      endcase
    end
  end

  // Bank state register.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      led  <= '0;
      wrap <= 1'b0;
    end else begin
      led  <= led_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
